// File: rtl/freq_meter_pkg.sv
// Shared types and defaults for the gated-window frequency meter.
package freq_meter_pkg;

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_GATE
  } state_e;

  localparam int unsigned CLK_HZ          = 50_000_000;
  localparam int unsigned GATE_CYCLES_DEF = CLK_HZ;
  localparam int unsigned CNT_W_DEF       = 8;
  localparam int unsigned FILT_LEN_DEF    = 3;

endpackage

// File: rtl/sig_sync_edge.sv
// SigIn synchronizer and rising-edge detector; the optional glitch filter
// is enabled with macro SIGIN_FILTER_EN.
module sig_sync_edge
  import freq_meter_pkg::*;
#(
  parameter int unsigned FILT_LEN = FILT_LEN_DEF
) (
  input  logic Clk50MHz,
  input  logic RST,
  input  logic SigIn,
  output logic rise
);

  if (FILT_LEN < 2) begin : g_filt_len_chk
    $error("FILT_LEN must be >= 2");
  end

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;
  logic level;

`ifdef SIGIN_FILTER_EN
  localparam int unsigned HW = FILT_LEN - 1;

  logic [HW-1:0] hist_q, hist_d;

  // prev_q doubles as the filter's held level: it only moves once the current
  // sample and the HW previous samples all agree.
  always_comb begin
    hist_d = (hist_q << 1) | HW'(sync2_q);
    level  = prev_q;
    if (sync2_q && (hist_q == '1)) begin
      level = 1'b1;
    end else if (!sync2_q && (hist_q == '0)) begin
      level = 1'b0;
    end
  end

  always_ff @(posedge Clk50MHz) begin
    if (RST) begin
      hist_q <= '0;
    end else begin
      hist_q <= hist_d;
    end
  end
`else
  always_comb begin
    level = sync2_q;
  end
`endif

  always_comb begin
    sync1_d = SigIn;
    sync2_d = sync1_q;
    prev_d  = level;
    rise    = level & ~prev_q;
  end

  always_ff @(posedge Clk50MHz) begin
    if (RST) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

endmodule

// File: rtl/freq_meter_gate1s.sv
// Counts SigIn rising edges over a GATE_CYCLES window of Clk50MHz and
// publishes the saturated count. Optional input filter: SIGIN_FILTER_EN.
module freq_meter_gate1s
  import freq_meter_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = GATE_CYCLES_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned FILT_LEN    = FILT_LEN_DEF
) (
  input  logic             Clk50MHz,
  input  logic             RST,
  input  logic             SS,
  input  logic             SigIn,
  output logic [CNT_W-1:0] Freq8_Out,
  output logic             Ovf,
  output logic             Valid
);

  if (GATE_CYCLES < 2) begin : g_gate_chk
    $error("GATE_CYCLES must be >= 2");
  end

  localparam int unsigned GW = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

  state_e           state_q,   state_d;
  logic [GW-1:0]    gate_q,    gate_d;
  logic [CNT_W-1:0] edge_q,    edge_d;
  logic             ovf_acc_q, ovf_acc_d;
  logic [CNT_W-1:0] freq_q,    freq_d;
  logic             ovf_q,     ovf_d;
  logic             valid_q,   valid_d;

  logic             rise;
  logic             sat;
  logic             terminal;
  logic [CNT_W-1:0] edge_inc;
  logic             ovf_inc;

  sig_sync_edge #(
    .FILT_LEN (FILT_LEN)
  ) u_sig_sync_edge (
    .Clk50MHz (Clk50MHz),
    .RST      (RST),
    .SigIn    (SigIn),
    .rise     (rise)
  );

  // The edge counter pins at all-ones; further rises only mark overflow.
  assign sat      = &edge_q;
  assign edge_inc = edge_q + CNT_W'(rise & ~sat);
  assign ovf_inc  = ovf_acc_q | (rise & sat);
  assign terminal = (state_q == ST_GATE) && (gate_q == GATE_LAST);

  always_comb begin
    state_d   = state_q;
    gate_d    = '0;
    edge_d    = '0;
    ovf_acc_d = 1'b0;
    freq_d    = freq_q;
    ovf_d     = ovf_q;
    valid_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (SS) begin
          state_d = ST_GATE;
        end
      end
      ST_GATE: begin
        // A terminal cycle completes even if SS drops on it; counters reload
        // on the same edge so back-to-back windows have no dead cycle.
        if (terminal) begin
          freq_d  = edge_inc;
          ovf_d   = ovf_inc;
          valid_d = 1'b1;
          if (!SS) begin
            state_d = ST_IDLE;
          end
        end else if (!SS) begin
          state_d = ST_IDLE;
        end else begin
          gate_d    = gate_q + GW'(1);
          edge_d    = edge_inc;
          ovf_acc_d = ovf_inc;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk50MHz) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      gate_q    <= '0;
      edge_q    <= '0;
      ovf_acc_q <= 1'b0;
      freq_q    <= '0;
      ovf_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      gate_q    <= gate_d;
      edge_q    <= edge_d;
      ovf_acc_q <= ovf_acc_d;
      freq_q    <= freq_d;
      ovf_q     <= ovf_d;
      valid_q   <= valid_d;
    end
  end

  assign Freq8_Out = freq_q;
  assign Ovf       = ovf_q;
  assign Valid     = valid_q;

endmodule

// File: tb/tb_freq_meter_gate1s.sv
// Scoreboard bench for freq_meter_gate1s: a 100-cycle-gate instance and a
// 2000-cycle-gate instance share clock, reset and SigIn.
module tb_freq_meter_gate1s;

  localparam int unsigned GA = 100;
  localparam int unsigned GB = 2000;

  typedef struct {
    logic [7:0] freq;
    logic       ovf;
  } exp_t;

  logic       clk    = 1'b0;
  logic       rst    = 1'b1;
  logic       ss_a   = 1'b0;
  logic       ss_b   = 1'b0;
  logic       sig_in = 1'b0;
  logic [7:0] freq_a, freq_b;
  logic       ovf_a, ovf_b, valid_a, valid_b;

  int checks = 0;
  int errors = 0;

  // SigIn generator: 0 = const low, 1 = const high, 2 = square wave, 3 = 1-cycle pulse every 10
  int mode = 0;
  int half = 5;
  int ph   = 0;

  exp_t qa[$];
  exp_t qb[$];
  logic va_prev = 1'b0;
  logic vb_prev = 1'b0;

  always #10 clk = ~clk;

  freq_meter_gate1s #(.GATE_CYCLES(GA), .CNT_W(8)) dut_a (
    .Clk50MHz (clk),
    .RST      (rst),
    .SS       (ss_a),
    .SigIn    (sig_in),
    .Freq8_Out(freq_a),
    .Ovf      (ovf_a),
    .Valid    (valid_a)
  );

  freq_meter_gate1s #(.GATE_CYCLES(GB), .CNT_W(8)) dut_b (
    .Clk50MHz (clk),
    .RST      (rst),
    .SS       (ss_b),
    .SigIn    (sig_in),
    .Freq8_Out(freq_b),
    .Ovf      (ovf_b),
    .Valid    (valid_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0:       sig_in = 1'b0;
        1:       sig_in = 1'b1;
        2:       sig_in = (ph % (2 * half)) < half;
        default: sig_in = (ph % 10) == 0;
      endcase
      ph++;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (va_prev) check("a_valid_width", valid_a, 0);
    if (valid_a) begin
      if (qa.size() == 0) begin
        check("a_unexpected_valid", valid_a, 0);
      end else begin
        e = qa.pop_front();
        check("a_freq", freq_a, e.freq);
        check("a_ovf", ovf_a, e.ovf);
      end
    end
    va_prev = valid_a;
  end

  always @(negedge clk) begin
    exp_t e;
    if (vb_prev) check("b_valid_width", valid_b, 0);
    if (valid_b) begin
      if (qb.size() == 0) begin
        check("b_unexpected_valid", valid_b, 0);
      end else begin
        e = qb.pop_front();
        check("b_freq", freq_b, e.freq);
        check("b_ovf", ovf_b, e.ovf);
      end
    end
    vb_prev = valid_b;
  end

  // n counts negedges until Valid is seen; SS/RST changes are made at posedge+1,
  // so a window entered on the next posedge reports at n = gate + 2.
  task automatic wait_valid(input bit sel_b, input int budget, output int n);
    n = 0;
    while (n < budget) begin
      @(negedge clk);
      n++;
      if (sel_b ? valid_b : valid_a) return;
    end
    check(sel_b ? "b_valid_timeout" : "a_valid_timeout", sel_b ? valid_b : valid_a, 1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    repeat (20) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0] pulse_exp;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("a_rst_freq", freq_a, 0);
    check("a_rst_ovf", ovf_a, 0);
    check("a_rst_valid", valid_a, 0);
    check("b_rst_freq", freq_b, 0);
    check("b_rst_ovf", ovf_b, 0);
    check("b_rst_valid", valid_b, 0);
    step();
    rst = 1'b0;

    // saturation on the long-gate instance, then recovery to an exact count
    mode = 2;
`ifdef SIGIN_FILTER_EN
    half = 3;
`else
    half = 2;
`endif
    settle();
    qb.push_back('{freq: 8'd255, ovf: 1'b1});
    ss_b = 1'b1;
    wait_valid(1'b1, GB + 10, n);
    check("b_sat_latency", n, GB + 2);
    step();
    ss_b = 1'b0;
    half = 5;
    settle();
    qb.push_back('{freq: 8'd200, ovf: 1'b0});
    ss_b = 1'b1;
    wait_valid(1'b1, GB + 10, n);
    check("b_recover_latency", n, GB + 2);
    step();
    ss_b = 1'b0;

    // back-to-back 100-cycle windows at period 10
    settle();
    repeat (3) qa.push_back('{freq: 8'd10, ovf: 1'b0});
    ss_a = 1'b1;
    wait_valid(1'b0, GA + 10, n);
    check("a_first_latency", n, GA + 2);
    repeat (2) begin
      wait_valid(1'b0, GA + 10, n);
      check("a_period", n, GA);
    end

    // abort at window cycle 50: nothing published, outputs held
    repeat (50) @(posedge clk);
    #1;
    ss_a = 1'b0;
    repeat (150) @(negedge clk);
    check("a_abort_hold_freq", freq_a, 10);
    check("a_abort_hold_ovf", ovf_a, 0);
    step();
    qa.push_back('{freq: 8'd10, ovf: 1'b0});
    ss_a = 1'b1;
    wait_valid(1'b0, GA + 10, n);
    check("a_reentry_latency", n, GA + 2);

    // reset mid-window, timed just after a SigIn fall
    repeat (60) @(posedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (((ph - 1) % 10) == 5) break;
    end
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("a_midrst_freq", freq_a, 0);
    check("a_midrst_ovf", ovf_a, 0);
    check("a_midrst_valid", valid_a, 0);
    qa.push_back('{freq: 8'd10, ovf: 1'b0});
    wait_valid(1'b0, GA + 10, n);
    check("a_post_rst_latency", n, GA + 1);

    // constant levels: no edges, Valid still pulses
    for (int lvl = 1; lvl >= 0; lvl--) begin
      step();
      ss_a = 1'b0;
      mode = lvl;
      settle();
      repeat (2) qa.push_back('{freq: 8'd0, ovf: 1'b0});
      ss_a = 1'b1;
      wait_valid(1'b0, GA + 10, n);
      check("a_const_latency", n, GA + 2);
      wait_valid(1'b0, GA + 10, n);
      check("a_const_period", n, GA);
    end

    // single-cycle pulses: counted unfiltered, rejected by the filter
`ifdef SIGIN_FILTER_EN
    pulse_exp = 8'd0;
`else
    pulse_exp = 8'd10;
`endif
    step();
    ss_a = 1'b0;
    mode = 3;
    settle();
    repeat (2) qa.push_back('{freq: pulse_exp, ovf: 1'b0});
    ss_a = 1'b1;
    repeat (2) wait_valid(1'b0, GA + 10, n);
    step();
    ss_a = 1'b0;
    repeat (5) @(negedge clk);
    check("a_queue_drained", qa.size(), 0);
    check("b_queue_drained", qb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
